// File: rtl/ram_reader_if.sv
// ram_reader_if: synchronous RAM read-port bundle.
// master = reader side, slave = RAM side.
interface ram_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport master (
    output mem_address,
    output mem_wren,
    input  mem_q
  );

  modport slave (
    input  mem_address,
    input  mem_wren,
    output mem_q
  );
endinterface

// File: rtl/ram_reader.sv
// ram_reader: sweeps a synchronous RAM, holding each word DWELL clocks.
// Define RAM_READER_CHECKSUM_EN to enable the running checksum.
module ram_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DWELL  = 50_000_000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  ram_reader_if.master      bus,
  output logic [ADDR_W-1:0] rd_address,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int CNT_W = 26;
  localparam logic [CNT_W-1:0] DWELL_M1 =
    CNT_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic              go;
  logic              capture;
  logic              finish;
  logic              advance;
  logic              abort;

  assign bus.mem_address = addr;
  assign bus.mem_wren    = 1'b0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    go      = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    advance = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = ISSUE;
          go      = 1'b1;
        end
      end
      ISSUE: begin
        if (stop) begin
          state_n = IDLE;
          abort   = 1'b1;
        end else begin
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (stop) begin
          state_n = IDLE;
          abort   = 1'b1;
        end else begin
          state_n = HOLD;
          capture = 1'b1;
        end
      end
      HOLD: begin
        if (stop) begin
          state_n = IDLE;
          abort   = 1'b1;
        end else if (cnt == '0) begin
          if (addr == LAST) begin
            state_n = IDLE;
            finish  = 1'b1;
          end else begin
            state_n = ISSUE;
            advance = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr       <= '0;
      cnt        <= '0;
      rd_address <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_valid <= capture;
      done     <= finish;
      if (go) begin
        addr <= '0;
        busy <= 1'b1;
      end
      if (abort || finish) begin
        busy <= 1'b0;
      end
      if (advance) begin
        addr <= addr + 1'b1;
      end
      if (capture) begin
        rd_data    <= bus.mem_q;
        rd_address <= addr;
        cnt        <= DWELL_M1;
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

`ifdef RAM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sum <= '0;
    end else if (go) begin
      sum <= '0;
    end else if (capture) begin
      sum <= sum + bus.mem_q;
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: directed bench for ram_reader with DWELL=3.
// Word i shows on edge 5i+2 after the start edge; done on edge 160.
module tb_ram_reader;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       stop;
  logic [4:0] rd_address;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic [7:0] checksum;
  logic [7:0] ram [32];
  int         checks;
  int         failures;

  ram_reader_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  ram_reader #(
    .ADDR_W(5),
    .DATA_W(8),
    .DWELL (3)
  ) dut (
    .clock     (clk),
    .resetn    (resetn),
    .start     (start),
    .stop      (stop),
    .bus       (bus),
    .rd_address(rd_address),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_q <= ram[bus.mem_address];

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input int mode);
    logic [7:0] exp_sum;
    logic [4:0] w;
    logic       exp_valid;
    exp_sum = 8'h00;
    for (int i = 0; i < 32; i++) exp_sum = exp_sum + ram[i];
`ifndef RAM_READER_CHECKSUM_EN
    exp_sum = 8'h00;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 165; k++) begin
      tick();
      if (mode == 1 && k == 52) start = 1'b0;
      if (mode == 2 && k == 160) stop = 1'b0;
      w = 5'((k - 2) / 5);
      exp_valid = (k % 5 == 2) && (k <= 157);
      chk("rd_valid", rd_valid, exp_valid);
      if (exp_valid) begin
        chk("rd_address", rd_address, w);
        chk("rd_data", rd_data, ram[w]);
      end
      chk("done", done, (k == 160 && mode != 2));
      chk("busy", busy, (k < 160));
      chk("mem_wren", bus.mem_wren, 1'b0);
      if (k == 160) chk("checksum", checksum, exp_sum);
      if (k == 165) begin
        chk("rd_data_hold", rd_data, ram[31]);
        chk("rd_addr_hold", rd_address, 5'd31);
      end
      if (mode == 1 && k == 51) start = 1'b1;
      if (mode == 2 && k == 159) stop = 1'b1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    for (int i = 0; i < 32; i++) ram[i] = 8'(i);
    #2 resetn = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_addr", bus.mem_address, 5'd0);
    chk("rst_checksum", checksum, 8'h00);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    run_sweep(0);
    run_sweep(1);

    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    chk("stopstart_busy", busy, 1'b0);
    tick();
    chk("stopstart_valid", rd_valid, 1'b0);
    chk("stopstart_busy2", busy, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 28; k++) tick();
    chk("pre_stop_busy", busy, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", busy, 1'b0);
    chk("stop_done", done, 1'b0);
    chk("stop_valid", rd_valid, 1'b0);
    chk("stop_rd_data", rd_data, 8'h05);
    chk("stop_rd_addr", rd_address, 5'd5);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("stopped_valid", rd_valid, 1'b0);
      chk("stopped_done", done, 1'b0);
      chk("stopped_data", rd_data, 8'h05);
    end
    run_sweep(0);

    for (int i = 0; i < 32; i++) ram[i] = 8'hFF;
    run_sweep(0);
`ifdef RAM_READER_CHECKSUM_EN
    chk("checksum_ff", checksum, 8'hE0);
`else
    chk("checksum_off", checksum, 8'h00);
`endif
    run_sweep(2);

    for (int i = 0; i < 32; i++) ram[i] = 8'(i + 8'h40);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 103; k++) tick();
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_addr", rd_address, 5'd20);
    chk("pre_rst_data", rd_data, 8'h54);
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_addr", rd_address, 5'd0);
    chk("arst_data", rd_data, 8'h00);
    chk("arst_valid", rd_valid, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_mem_addr", bus.mem_address, 5'd0);
    chk("arst_checksum", checksum, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_valid", rd_valid, 1'b0);
      chk("post_rst_done", done, 1'b0);
      chk("post_rst_mem", bus.mem_address, 5'd0);
      chk("post_rst_wren", bus.mem_wren, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
